// File: rtl/sa_csr_axil_pkg.sv
// sa_csr_axil_pkg: register map, response codes, reset defaults and job record for the SA CSR block.
package sa_csr_axil_pkg;
    localparam int CFG_WORDS = 12;
    localparam int ADDR_CONTROL = 'h00;
    localparam int ADDR_STATUS = 'h04;
    localparam int ADDR_CFG0 = 'h08;
    localparam int ADDR_PERF_CYCLES = 'h38;
    localparam int ADDR_PERF_JOBS = 'h3C;
    localparam int CTRL_START = 0;
    localparam int CTRL_UPDATE_A = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERROR = 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [31:0] DEFAULT_N = 32'd16;
    localparam logic [31:0] DEFAULT_K = 32'd16;
    localparam logic [31:0] DEFAULT_M = 32'd16;
    localparam logic [31:0] DEFAULT_TILE_SIZE = 32'd16;
    localparam logic [31:0] DEFAULT_BLOCK_M = 32'd16;

    typedef struct packed {
        logic update_a;
        logic [CFG_WORDS*32-1:0] cfg;
    } sa_job_t;

    function automatic logic [31:0] cfg_default(input int i);
        return i == 2 ? DEFAULT_N : i == 3 ? DEFAULT_K : i == 4 ? DEFAULT_M :
               i == 5 ? DEFAULT_TILE_SIZE : i == 6 ? DEFAULT_BLOCK_M : 32'd0;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] nv,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nv[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/sa_csr_axil_if.sv
// sa_csr_axil_if: AXI4-Lite bus bundle with master/slave views.
interface sa_csr_axil_if #(parameter int ADDR_W = 12, parameter int DATA_W = 32);
    logic [ADDR_W-1:0] awaddr;
    logic awvalid, awready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic wvalid, wready;
    logic [1:0] bresp;
    logic bvalid, bready;
    logic [ADDR_W-1:0] araddr;
    logic arvalid, arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0] rresp;
    logic rvalid, rready;

    modport master(output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                   input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
    modport slave(input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
                  output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
endinterface

// File: rtl/sa_csr_axil_cmd_fifo.sv
// sa_cmd_fifo: power-of-2 FIFO holding job snapshots; push is refused when full (pre-pop level).
module sa_cmd_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;

    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = mem[rp];

    always_ff @(posedge clk) if (do_push) mem[wp] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/sa_csr_axil.sv
// sa_csr_axil: AXI4-Lite CSR slave feeding a job queue to the systolic-array controller.
// Define SA_CSR_PERF_CNT_EN to add the PERF_CYCLES/PERF_JOBS counters at 0x38/0x3C.
module sa_csr_axil
    import sa_csr_axil_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int NUM_CFG = CFG_WORDS,
    parameter int CMD_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sa_csr_axil_if.slave           s,
    output logic                   job_valid,
    input  logic                   job_ready,
    output logic [NUM_CFG*32-1:0]  job_cfg,
    output logic                   job_update_a,
    input  logic                   core_done,
    input  logic                   core_error,
    output logic                   irq
);
    localparam int LW = $clog2(CMD_DEPTH) + 1;
    localparam int JW = NUM_CFG*32 + 1;
    localparam int W_CTRL = ADDR_CONTROL / 4;
    localparam int W_STAT = ADDR_STATUS / 4;
    localparam int W_CFG0 = ADDR_CFG0 / 4;

    logic alive, aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic [3:0] w_strb;
    logic [2:1] ctrl;
    logic done, err, inflight, busy;
    logic [DATA_W-1:0] cfg [NUM_CFG];
    logic [NUM_CFG*32-1:0] cfg_flat;
    logic [JW-1:0] head;
    logic [LW-1:0] level;
    logic fifo_full, fifo_empty, push, pop;
    logic wr_en, wr_ctrl, wr_stat, wr_mapped, start, overflow, clr_done, clr_err;
    int wi, ri;
    logic [DATA_W-1:0] rd_val;
    logic rd_hit;
    logic unused;

    assign unused = ^{aw_addr[1:0], s.araddr[1:0]};
    // Ready is held off for the first cycle after reset so nothing is accepted while in reset.
    assign s.awready = alive & ~aw_held & ~s.bvalid;
    assign s.wready = alive & ~w_held & ~s.bvalid;
    assign s.arready = alive & ~s.rvalid;

    assign wi = int'(aw_addr[ADDR_W-1:2]);
    assign ri = int'(s.araddr[ADDR_W-1:2]);
    assign wr_en = aw_held & w_held;
    assign wr_ctrl = wr_en && wi == W_CTRL;
    assign wr_stat = wr_en && wi == W_STAT;
    assign start = wr_ctrl & w_strb[0] & w_data[CTRL_START];
    assign overflow = start & fifo_full;
    assign push = start & ~fifo_full;
    assign pop = job_valid & job_ready;
    assign clr_done = wr_stat & w_strb[0] & w_data[STAT_DONE];
    assign clr_err = wr_stat & w_strb[0] & w_data[STAT_ERROR];
    assign busy = ~fifo_empty | inflight;
    assign job_valid = ~fifo_empty;
    assign job_cfg = head[NUM_CFG*32-1:0];
    assign job_update_a = head[JW-1];

    for (genvar i = 0; i < NUM_CFG; i++) begin : g_flat
        assign cfg_flat[32*i +: 32] = cfg[i];
    end

`ifdef SA_CSR_PERF_CNT_EN
    logic [31:0] perf_cycles, perf_jobs;
    assign wr_mapped = wi < W_CFG0 + NUM_CFG || wi == ADDR_PERF_CYCLES / 4 || wi == ADDR_PERF_JOBS / 4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_jobs <= '0;
        end else begin
            if (pop) perf_cycles <= '0;
            else if (inflight && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
            if (wr_en && wi == ADDR_PERF_JOBS / 4) perf_jobs <= '0;
            else if (core_done | core_error) perf_jobs <= perf_jobs + 1'b1;
        end
    end
`else
    assign wr_mapped = wi < W_CFG0 + NUM_CFG;
`endif

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b1;
        for (int i = 0; i < NUM_CFG; i++) if (ri == W_CFG0 + i) rd_val = cfg[i];
        if (ri == W_CTRL) rd_val = {29'b0, ctrl, 1'b0};
        else if (ri == W_STAT) rd_val = {16'b0, 8'(level), 5'b0, err, done, busy};
`ifdef SA_CSR_PERF_CNT_EN
        else if (ri == ADDR_PERF_CYCLES / 4) rd_val = perf_cycles;
        else if (ri == ADDR_PERF_JOBS / 4) rd_val = perf_jobs;
`endif
        else if (ri >= W_CFG0 + NUM_CFG || ri < W_CFG0) rd_hit = 1'b0;
    end

    sa_cmd_fifo #(.WIDTH(JW), .DEPTH(CMD_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .din({w_strb[0] ? w_data[CTRL_UPDATE_A] : ctrl[CTRL_UPDATE_A], cfg_flat}),
        .dout(head), .full(fifo_full), .empty(fifo_empty), .level(level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive <= 1'b0;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            aw_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            s.bvalid <= 1'b0;
            s.bresp <= RESP_OKAY;
            ctrl <= '0;
            done <= 1'b0;
            err <= 1'b0;
            inflight <= 1'b0;
            irq <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) cfg[i] <= cfg_default(i);
        end else begin
            alive <= 1'b1;
            if (s.awvalid && s.awready) begin
                aw_held <= 1'b1;
                aw_addr <= s.awaddr;
            end
            if (s.wvalid && s.wready) begin
                w_held <= 1'b1;
                w_data <= s.wdata;
                w_strb <= s.wstrb;
            end
            if (wr_en) begin
                aw_held <= 1'b0;
                w_held <= 1'b0;
                s.bvalid <= 1'b1;
                s.bresp <= (!wr_mapped || overflow) ? RESP_SLVERR : RESP_OKAY;
            end else if (s.bready) s.bvalid <= 1'b0;
            if (wr_ctrl && w_strb[0]) ctrl <= w_data[2:1];
            for (int i = 0; i < NUM_CFG; i++)
                if (wr_en && wi == W_CFG0 + i) cfg[i] <= apply_strb(cfg[i], w_data, w_strb);
            // Hardware set beats a same-cycle W1C.
            done <= core_done | (done & ~clr_done);
            err <= core_error | overflow | (err & ~clr_err);
            inflight <= pop | (inflight & ~(core_done | core_error));
            irq <= ctrl[CTRL_IRQ_EN] & (done | err);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.rvalid <= 1'b0;
            s.rdata <= '0;
            s.rresp <= RESP_OKAY;
        end else if (s.arvalid && s.arready) begin
            s.rvalid <= 1'b1;
            s.rdata <= rd_hit ? rd_val : '0;
            s.rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (s.rready) s.rvalid <= 1'b0;
    end
endmodule

// File: tb/tb_sa_csr_axil.sv
// tb_sa_csr_axil: directed and randomized checks of sa_csr_axil against a queue-based register model.
module tb_sa_csr_axil;
    import sa_csr_axil_pkg::*;
    localparam int DEPTH = 4;

    logic clk = 0, rst_n = 0;
    logic job_valid, job_ready = 0, job_update_a, core_done = 0, core_error = 0, irq;
    logic [383:0] job_cfg;
    int total = 0, bad = 0;

    sa_csr_axil_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    sa_csr_axil #(.ADDR_W(12), .DATA_W(32), .NUM_CFG(12), .CMD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .s(bus), .job_valid(job_valid), .job_ready(job_ready),
        .job_cfg(job_cfg), .job_update_a(job_update_a), .core_done(core_done),
        .core_error(core_error), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [31:0] mcfg [12];
    logic m_upd, m_irqen, m_done, m_err, m_infl;
    sa_job_t mq[$];

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        for (int i = 0; i < 12; i++) mcfg[i] = 0;
        mcfg[2] = DEFAULT_N; mcfg[3] = DEFAULT_K; mcfg[4] = DEFAULT_M;
        mcfg[5] = DEFAULT_TILE_SIZE; mcfg[6] = DEFAULT_BLOCK_M;
        {m_upd, m_irqen, m_done, m_err, m_infl} = '0;
    endfunction

    function automatic logic [383:0] m_flat();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[32*i +: 32] = mcfg[i];
        return r;
    endfunction

    function automatic logic [1:0] m_write(input int w, input logic [31:0] d, input logic [3:0] s);
        sa_job_t j;
        if (w == 0) begin
            if (s[0]) begin
                m_upd = d[1];
                m_irqen = d[2];
                if (d[0]) begin
                    if (mq.size() == DEPTH) begin
                        m_err = 1;
                        return 2'b10;
                    end
                    j.cfg = m_flat();
                    j.update_a = m_upd;
                    mq.push_back(j);
                end
            end
            return 2'b00;
        end
        if (w == 1) begin
            if (s[0] && d[1]) m_done = 0;
            if (s[0] && d[2]) m_err = 0;
            return 2'b00;
        end
        if (w >= 2 && w < 14) begin
            for (int b = 0; b < 4; b++) if (s[b]) mcfg[w-2][8*b +: 8] = d[8*b +: 8];
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic logic [31:0] m_read(input int w, output logic [1:0] r);
        r = 2'b00;
        if (w == 0) return {29'b0, m_irqen, m_upd, 1'b0};
        if (w == 1) return {16'b0, 8'(mq.size()), 5'b0, m_err, m_done, mq.size() != 0 || m_infl};
        if (w >= 2 && w < 14) return mcfg[w-2];
        r = 2'b10;
        return 0;
    endfunction

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] resp);
        int n = 0;
        logic aw_hs, w_hs;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = st; bus.awvalid = 1; bus.wvalid = 1;
        while ((bus.awvalid || bus.wvalid) && n < 50) begin
            aw_hs = bus.awvalid & bus.awready;
            w_hs = bus.wvalid & bus.wready;
            @(posedge clk); #1;
            if (aw_hs) bus.awvalid = 0;
            if (w_hs) bus.wvalid = 0;
            n++;
        end
        bus.bready = 1;
        while (!bus.bvalid && n < 50) begin @(posedge clk); #1; n++; end
        resp = bus.bresp;
        @(posedge clk); #1;
        bus.bready = 0; bus.awvalid = 0; bus.wvalid = 0;
        check("wr_timeout", 384'(n >= 50), 0);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        bus.araddr = a; bus.arvalid = 1;
        while (!bus.arready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.arvalid = 0; bus.rready = 1;
        while (!bus.rvalid && n < 50) begin @(posedge clk); #1; n++; end
        d = bus.rdata; resp = bus.rresp;
        @(posedge clk); #1;
        bus.rready = 0;
        check("rd_timeout", 384'(n >= 50), 0);
    endtask

    task automatic wr(input string tag, input int a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r, e;
        axi_write(12'(a), d, s, r);
        e = m_write(a / 4, d, s);
        check(tag, r, e);
    endtask

    task automatic rd(input string tag, input int a, output logic [31:0] d);
        logic [1:0] r, er;
        logic [31:0] e;
        axi_read(12'(a), d, r);
        e = m_read(a / 4, er);
        check(tag, d, e);
        check({tag, "_resp"}, r, er);
    endtask

    task automatic pop_job();
        sa_job_t j;
        check("job_valid", job_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("job_cfg", job_cfg, mq[0].cfg);
            check("job_upd", job_update_a, mq[0].update_a);
            job_ready = 1; @(posedge clk); #1; job_ready = 0;
            j = mq.pop_front();
            m_infl = 1;
        end
    endtask

    task automatic async_reset();
        #3 rst_n = 0;
        #1 check("rst_job_valid", job_valid, 0);
        @(posedge clk); #1;
        rst_n = 1;
        m_reset();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0] r;
        int n;
        {bus.awaddr, bus.awvalid, bus.wdata, bus.wstrb, bus.wvalid, bus.bready} = '0;
        {bus.araddr, bus.arvalid, bus.rready} = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {bus.awready, bus.wready, bus.arready}, 0);
        check("rst_valid", {bus.bvalid, bus.rvalid, job_valid, irq}, 0);
        check("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 0);
        rst_n = 1;
        @(posedge clk); #1;
        rd("rst_n_word", 'h10, d);
        check("rst_n_default", d, DEFAULT_N);
        rd("rst_status", 'h04, d);
        check("rst_irq", irq, 0);

        wr("wr_n", 'h10, 64, 4'hF);
        wr("wr_k", 'h14, 32, 4'hF);
        wr("wr_m", 'h18, 16, 4'hF);
        wr("wr_start", 'h00, 1, 4'h1);
        check("start_job_valid", job_valid, 1);
        check("start_job_n", job_cfg[95:64], 64);
        check("start_job_cfg", job_cfg, mq[0].cfg);
        rd("ctrl_selfclr", 'h00, d);
        rd("status_one", 'h04, d);
        check("status_one_const", d, 32'h0000_0101);
        wr("wr_start2", 'h00, 1, 4'h1);
        async_reset();
        rd("status_after_rst", 'h04, d);
        check("level_after_rst", d[15:8], 0);

        for (int i = 0; i < 5; i++) wr("fill_start", 'h00, 1, 4'h1);
        rd("status_full", 'h04, d);
        check("status_full_const", d, 32'h0000_0405);

        wr("clr_err", 'h04, 4, 4'h1);
        wr("irq_en", 'h00, 4, 4'h1);
        check("irq_idle", irq, 0);
        pop_job();
        core_done = 1; @(posedge clk); #1; core_done = 0;
        m_done = 1; m_infl = 0;
        check("irq_lag", irq, 0);
        @(posedge clk); #1;
        check("irq_set", irq, 1);
        wr("clr_done", 'h04, 2, 4'h1);
        check("irq_clr", irq, 0);
        pop_job();
        bus.awaddr = 'h04; bus.wdata = 2; bus.wstrb = 1; bus.awvalid = 1; bus.wvalid = 1;
        @(posedge clk); #1;
        bus.awvalid = 0; bus.wvalid = 0; core_done = 1;
        @(posedge clk); #1;
        core_done = 0; m_done = 1; m_infl = 0;
        bus.bready = 1; n = 0;
        while (!bus.bvalid && n < 20) begin @(posedge clk); #1; n++; end
        check("w1c_race_bresp", {bus.bvalid, bus.bresp}, {1'b1, 2'b00});
        @(posedge clk); #1; bus.bready = 0;
        rd("w1c_race_status", 'h04, d);
        check("w1c_race_done", d[1], 1);

        bus.awaddr = 'h1C; bus.awvalid = 1;
        @(posedge clk); #1; bus.awvalid = 0;
        for (int i = 0; i < 3; i++) begin
            check("aw_early_awready", bus.awready, 0);
            check("aw_early_bvalid", bus.bvalid, 0);
            @(posedge clk); #1;
        end
        bus.wdata = 32'hA5A5_0001; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(posedge clk); #1; bus.wvalid = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check("bhold_bvalid", bus.bvalid, 1);
            check("bhold_ready", {bus.awready, bus.wready}, 0);
            @(posedge clk); #1;
        end
        check("bhold_bresp", bus.bresp, 2'b00);
        bus.bready = 1; @(posedge clk); #1; bus.bready = 0;
        check("bhold_done", bus.bvalid, 0);
        void'(m_write(7, 32'hA5A5_0001, 4'hF));
        rd("aw_early_readback", 'h1C, d);

        rd("unmapped_ffc", 'hFFC, d);
        rd("unmapped_perf", 'h38, d);
        wr("unmapped_wr", 'hFFC, 32'hFFFF_FFFF, 4'hF);
        wr("strb_partial", 'h20, 32'h1234_5678, 4'b0101);
        rd("strb_readback", 'h20, d);

        wr("q2_start", 'h00, 1, 4'h1);
        check("q2_level", mq.size(), 3);
        async_reset();
        check("q_flushed_valid", job_valid, 0);
        rd("q_flushed_status", 'h04, d);

        for (int it = 0; it < 120; it++) begin
            int op, w;
            logic dn, er;
            op = $urandom_range(0, 5);
            case (op)
                0: wr("rnd_cfg", $urandom_range(2, 13) * 4, $urandom, 4'($urandom_range(0, 15)));
                1: wr("rnd_start", 0, {29'b0, 1'($urandom), 1'($urandom), 1'b1}, 4'h1);
                2: begin
                    w = $urandom_range(0, 14);
                    rd("rnd_rd", w == 14 ? 'hFFC : w * 4, d);
                end
                3: wr("rnd_w1c", 4, {29'b0, 2'($urandom), 1'b0}, 4'h1);
                4: pop_job();
                default: if (m_infl) begin
                    dn = 1'($urandom); er = ~dn | 1'($urandom);
                    core_done = dn; core_error = er;
                    @(posedge clk); #1;
                    core_done = 0; core_error = 0;
                    m_done |= dn; m_err |= er; m_infl = 0;
                    @(posedge clk); #1;
                end
            endcase
            check("rnd_irq", irq, m_irqen & (m_done | m_err));
            check("rnd_job_valid", job_valid, mq.size() != 0);
        end
        rd("final_status", 'h04, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
